// File: rtl/mem_burst_arbiter_pkg.sv
// Shared types and constants for the memory burst arbiter.
// State encoding, requester IDs and beat/offset width helpers.
package mem_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_IC = 2'b01,
        GNT_DC = 2'b10
    } state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

    localparam int BURST_LEN   = 8;
    localparam int BEAT_BITS   = $clog2(BURST_LEN);
    localparam int OFFSET_BITS = BEAT_BITS + 2;

    function automatic int beat_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the arbiter.
// master = arbiter view, slave = caches/memory view.
interface mem_burst_arbiter_if
    import mem_burst_arbiter_pkg::*;
#(
    parameter int Width     = 32,
    parameter int Width_ADD = 32,
    parameter int Burst_len = 8
);
    localparam int BB = beat_bits(Burst_len);

    logic                 IC_REQ;
    logic [Width_ADD-1:0] IC_ADDR;
    logic [Width-1:0]     IC_Data;
    logic                 IC_Valid;
    logic [BB-1:0]        IC_WORD;
    logic                 IC_Done;

    logic                 DC_REQ;
    logic                 DC_WE;
    logic [Width_ADD-1:0] DC_ADDR;
    logic [Width-1:0]     DC_WDATA;
    logic [Width-1:0]     DC_Data;
    logic                 DC_Valid;
    logic [BB-1:0]        DC_WORD;
    logic                 DC_Done;

    logic                 MEM_REQ;
    logic                 MEM_WE;
    logic [Width_ADD-1:0] MEM_ADDR;
    logic [Width-1:0]     MEM_WDATA;
    logic                 MEM_Ack;
    logic [Width-1:0]     MEM_RDATA;

    modport master (
        input  IC_REQ, IC_ADDR,
        input  DC_REQ, DC_WE, DC_ADDR, DC_WDATA,
        input  MEM_Ack, MEM_RDATA,
        output IC_Data, IC_Valid, IC_WORD, IC_Done,
        output DC_Data, DC_Valid, DC_WORD, DC_Done,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        output IC_REQ, IC_ADDR,
        output DC_REQ, DC_WE, DC_ADDR, DC_WDATA,
        output MEM_Ack, MEM_RDATA,
        input  IC_Data, IC_Valid, IC_WORD, IC_Done,
        input  DC_Data, DC_Valid, DC_WORD, DC_Done,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
    );

endinterface

// File: rtl/mem_burst_beat_counter.sv
// Word index within a cache-line burst.
// Clear has priority; advances on each accepted beat.
module mem_burst_beat_counter
    import mem_burst_arbiter_pkg::*;
#(
    parameter int Burst_len = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            en,
    output logic [beat_bits(Burst_len)-1:0] beat,
    output logic                            last
);
    localparam int BB = beat_bits(Burst_len);

    // Power-of-two length, so natural overflow is the wrap to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (en) begin
            beat <= beat + 1'b1;
        end
    end

    assign last = (beat == BB'(Burst_len - 1));

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and
// D-cache line bursts; returns each beat with its word index.
module mem_burst_arbiter
    import mem_burst_arbiter_pkg::*;
#(
    parameter int Width     = 32,
    parameter int Width_ADD = 32,
    parameter int Burst_len = 8
) (
    input  logic                CLK,
    input  logic                RST,
    mem_burst_arbiter_if.master bus
);
    localparam int BB = beat_bits(Burst_len);
    localparam int OB = BB + 2;
    localparam logic [Width_ADD-1:0] OFF_MASK = Width_ADD'((1 << OB) - 1);

    state_t               state, state_nxt;
    logic [Width_ADD-1:0] base_q, base_nxt;
    logic                 we_q, we_nxt;
    req_id_t              ptr_q;
    logic                 clr, en, last;
    logic [BB-1:0]        beat;
    logic [Width_ADD-1:0] beat_addr;

    mem_burst_beat_counter #(.Burst_len(Burst_len)) u_beat (
        .clk  (CLK),
        .rst  (RST),
        .clr  (clr),
        .en   (en),
        .beat (beat),
        .last (last)
    );

    assign beat_addr = base_q + (Width_ADD'(beat) << 2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            base_q <= '0;
            we_q   <= 1'b0;
            ptr_q  <= REQ_DC;
        end else begin
            state  <= state_nxt;
            base_q <= base_nxt;
            we_q   <= we_nxt;
            if (en && last) begin
                ptr_q <= (state == GNT_DC) ? REQ_DC : REQ_IC;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        base_nxt      = base_q;
        we_nxt        = we_q;
        clr           = 1'b0;
        en            = 1'b0;
        bus.IC_Data   = '0;
        bus.IC_Valid  = 1'b0;
        bus.IC_WORD   = '0;
        bus.IC_Done   = 1'b0;
        bus.DC_Data   = '0;
        bus.DC_Valid  = 1'b0;
        bus.DC_WORD   = '0;
        bus.DC_Done   = 1'b0;
        bus.MEM_REQ   = 1'b0;
        bus.MEM_WE    = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        unique case (state)
            IDLE: begin
                // On a tie, the side that did not finish last wins
                if (bus.IC_REQ && (!bus.DC_REQ || ptr_q == REQ_DC)) begin
                    state_nxt = GNT_IC;
                    base_nxt  = bus.IC_ADDR & ~OFF_MASK;
                    we_nxt    = 1'b0;
                    clr       = 1'b1;
                end else if (bus.DC_REQ) begin
                    state_nxt = GNT_DC;
                    base_nxt  = bus.DC_ADDR & ~OFF_MASK;
                    we_nxt    = bus.DC_WE;
                    clr       = 1'b1;
                end
            end
            GNT_IC: begin
                bus.MEM_REQ  = 1'b1;
                bus.MEM_ADDR = beat_addr;
                bus.MEM_WE   = we_q;
                bus.IC_WORD  = beat;
                if (bus.MEM_Ack) begin
                    en           = 1'b1;
                    bus.IC_Valid = 1'b1;
                    bus.IC_Data  = we_q ? Width'(0) : bus.MEM_RDATA;
                    bus.IC_Done  = last;
                    if (last) state_nxt = IDLE;
                end
            end
            GNT_DC: begin
                bus.MEM_REQ   = 1'b1;
                bus.MEM_ADDR  = beat_addr;
                bus.MEM_WE    = we_q;
                bus.MEM_WDATA = we_q ? bus.DC_WDATA : Width'(0);
                bus.DC_WORD   = beat;
                if (bus.MEM_Ack) begin
                    en           = 1'b1;
                    bus.DC_Valid = 1'b1;
                    bus.DC_Data  = we_q ? Width'(0) : bus.MEM_RDATA;
                    bus.DC_Done  = last;
                    if (last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: directed bursts push expected
// beats; a negedge monitor pops and compares every returned beat.
module tb_mem_burst_arbiter;
    import mem_burst_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_burst_arbiter_if bus ();

    mem_burst_arbiter dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dc;
        logic [2:0]  word;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        done;
        logic [36:0] other;
    } beat_t;

    beat_t q[$];
    int n_pass  = 0;
    int n_total = 0;
    int ack_mode = 0;
    int cyc;

    // Memory returns a recognisable function of the address
    assign bus.MEM_RDATA = bus.MEM_ADDR ^ 32'hDEAD_BEEF;
    assign bus.DC_WDATA  = 32'hC0DE_0000 | 32'(bus.DC_WORD);

    initial begin
        int cnt;
        cnt = 0;
        bus.MEM_Ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            bus.MEM_Ack = (ack_mode == 0) ? 1'b1 : (cnt % 3 == 0);
        end
    end

    task automatic chk(input bit ok, input string name, input string msg);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, msg);
    endtask

    always @(negedge clk) begin
        beat_t a, e;
        if (!rst) begin
            if (bus.IC_Valid || bus.DC_Valid) begin
                a.dc    = bus.DC_Valid;
                a.word  = a.dc ? bus.DC_WORD : bus.IC_WORD;
                a.addr  = bus.MEM_ADDR;
                a.we    = bus.MEM_WE;
                a.wdata = bus.MEM_WDATA;
                a.data  = a.dc ? bus.DC_Data : bus.IC_Data;
                a.done  = a.dc ? bus.DC_Done : bus.IC_Done;
                a.other = a.dc ?
                    {bus.IC_Valid, bus.IC_Done, bus.IC_WORD, bus.IC_Data} :
                    {bus.DC_Valid, bus.DC_Done, bus.DC_WORD, bus.DC_Data};
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", $sformatf("got %h required none", a));
                end else begin
                    e = q.pop_front();
                    chk(a == e, "beat", $sformatf("got %h required %h", a, e));
                end
            end else begin
                chk(!bus.IC_Done && !bus.DC_Done &&
                    bus.IC_Data == 0 && bus.DC_Data == 0, "idle_outputs",
                    $sformatf("got done=%b%b data=%h/%h required 0",
                              bus.IC_Done, bus.DC_Done, bus.IC_Data, bus.DC_Data));
                if (bus.MEM_REQ && q.size() > 0) begin
                    chk({bus.MEM_ADDR, bus.MEM_WE, bus.MEM_WDATA} ==
                        {q[0].addr, q[0].we, q[0].wdata}, "hold",
                        $sformatf("got addr=%h we=%b wd=%h required addr=%h we=%b wd=%h",
                                  bus.MEM_ADDR, bus.MEM_WE, bus.MEM_WDATA,
                                  q[0].addr, q[0].we, q[0].wdata));
                end
            end
        end
    end

    task automatic push_burst(input bit dc, input logic [31:0] addr,
                              input bit we, input int n);
        beat_t e;
        logic [31:0] base;
        base = addr & ~32'h1F;
        for (int i = 0; i < n; i++) begin
            e.dc    = dc;
            e.word  = 3'(i);
            e.addr  = base + 32'(4 * i);
            e.we    = we;
            e.wdata = (dc && we) ? (32'hC0DE_0000 | 32'(i)) : 32'h0;
            e.data  = we ? 32'h0 : (e.addr ^ 32'hDEAD_BEEF);
            e.done  = (i == 7);
            e.other = '0;
            q.push_back(e);
        end
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (q.size() != 0 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk(q.size() == 0, "drain", $sformatf("got %0d beats pending required 0", q.size()));
    endtask

    task automatic wait_size(input int target, input int budget);
        int c;
        c = 0;
        while (q.size() > target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(q.size() == target, "wait_size",
            $sformatf("got %0d pending required %0d", q.size(), target));
    endtask

    task automatic check_zero(input string name);
        logic [139:0] o;
        o = {bus.IC_Data, bus.IC_Valid, bus.IC_WORD, bus.IC_Done,
             bus.DC_Data, bus.DC_Valid, bus.DC_WORD, bus.DC_Done,
             bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA};
        chk(o == '0, name, $sformatf("got %h required 0", o));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.IC_REQ  = 1'b0;
        bus.IC_ADDR = '0;
        bus.DC_REQ  = 1'b0;
        bus.DC_WE   = 1'b0;
        bus.DC_ADDR = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single IC refill, zero-wait memory
        bus.IC_ADDR = 32'h0000_1234;
        bus.IC_REQ  = 1'b1;
        push_burst(1'b0, 32'h0000_1234, 1'b0, 8);
        @(negedge clk);
        chk(bus.MEM_REQ == 1'b0, "t1_latency", $sformatf("got MEM_REQ=%b required 0", bus.MEM_REQ));
        drain(40, cyc);
        chk(cyc == 9, "t1_cycles", $sformatf("got %0d required 9", cyc));
        bus.IC_REQ = 1'b0;
        @(negedge clk);
        chk(bus.MEM_REQ == 1'b0, "t1_turnaround", $sformatf("got MEM_REQ=%b required 0", bus.MEM_REQ));
        @(posedge clk);
        #1;

        // 2: simultaneous requests after reset: IC, DC, IC
        do_reset();
        bus.IC_ADDR = 32'h0000_2000;
        bus.DC_ADDR = 32'h0000_3010;
        bus.DC_WE   = 1'b0;
        bus.IC_REQ  = 1'b1;
        bus.DC_REQ  = 1'b1;
        push_burst(1'b0, 32'h0000_2000, 1'b0, 8);
        push_burst(1'b1, 32'h0000_3010, 1'b0, 8);
        push_burst(1'b0, 32'h0000_2000, 1'b0, 8);
        drain(100, cyc);
        chk(cyc == 27, "t2_cycles", $sformatf("got %0d required 27", cyc));
        bus.IC_REQ = 1'b0;
        bus.DC_REQ = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 3: DC write-back with Ack every third cycle
        ack_mode    = 1;
        bus.DC_ADDR = 32'h0000_0400;
        bus.DC_WE   = 1'b1;
        bus.DC_REQ  = 1'b1;
        push_burst(1'b1, 32'h0000_0400, 1'b1, 8);
        drain(200, cyc);
        bus.DC_REQ = 1'b0;
        bus.DC_WE  = 1'b0;
        ack_mode   = 0;
        repeat (3) @(posedge clk);
        #1;

        // 4: reset at beat 4 of an IC burst, then restart
        bus.IC_ADDR = 32'h0000_5A5C;
        bus.IC_REQ  = 1'b1;
        push_burst(1'b0, 32'h0000_5A5C, 1'b0, 4);
        drain(40, cyc);
        chk(cyc == 5, "t4_pre_cycles", $sformatf("got %0d required 5", cyc));
        rst = 1'b1;
        @(negedge clk);
        check_zero("t4_reset_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_burst(1'b0, 32'h0000_5A5C, 1'b0, 8);
        drain(40, cyc);
        chk(cyc == 9, "t4_restart_cycles", $sformatf("got %0d required 9", cyc));
        bus.IC_REQ = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5: IC drops REQ mid-burst; waiting DC follows the turnaround
        do_reset();
        bus.IC_ADDR = 32'h8000_0010;
        bus.DC_ADDR = 32'h0000_2468;
        bus.DC_WE   = 1'b0;
        bus.IC_REQ  = 1'b1;
        bus.DC_REQ  = 1'b1;
        push_burst(1'b0, 32'h8000_0010, 1'b0, 8);
        push_burst(1'b1, 32'h0000_2468, 1'b0, 8);
        wait_size(14, 20);
        bus.IC_REQ = 1'b0;
        drain(60, cyc);
        chk(cyc == 15, "t5_cycles", $sformatf("got %0d required 15", cyc));
        bus.DC_REQ = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares the single external instruction/data memory port between the I-cache line refill and the D-cache refill/write-back.
- Grants one requester at a time, round-robin, and sequences a full cache-line burst of Burst_len word beats.
- Returns each beat to the granted cache with its word index, so the cache can write the line word by word.
- Sits between both cache controllers and the memory interface.

Parameters:
- Width, 32, data word width.
- Width_ADD, 32, address width.
- Burst_len, 8, words per cache line (256-bit block / 32-bit word). Must be a power of two.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous, active-high reset.
- IC_REQ  input  1  I-cache line-refill request (read only).
- IC_ADDR  input  Width_ADD  I-cache miss address.
- IC_Data  output  Width  refill word to I-cache.
- IC_Valid  output  1  IC_Data valid this cycle.
- IC_WORD  output  log2(Burst_len)  word index of current IC beat.
- IC_Done  output  1  one-cycle pulse on the last IC beat.
- DC_REQ  input  1  D-cache burst request.
- DC_WE  input  1  1 = write-back burst, 0 = refill.
- DC_ADDR  input  Width_ADD  D-cache line address.
- DC_WDATA  input  Width  write-back word for index DC_WORD.
- DC_Data  output  Width  refill word to D-cache.
- DC_Valid  output  1  DC refill word valid, or write beat accepted.
- DC_WORD  output  log2(Burst_len)  word index of current DC beat.
- DC_Done  output  1  one-cycle pulse on the last DC beat.
- MEM_REQ  output  1  beat request to memory.
- MEM_WE  output  1  write beat.
- MEM_ADDR  output  Width_ADD  beat address.
- MEM_WDATA  output  Width  write data.
- MEM_Ack  input  1  memory accepted a write beat or returned read data this cycle.
- MEM_RDATA  input  Width  read data, valid with MEM_Ack.

Behaviour:
- **States:** IDLE, GNT_IC, GNT_DC. State, beat counter, latched base address, latched DC_WE and last-grant pointer are all registered.
- **Reset:** all outputs 0, state IDLE, beat counter 0. Pointer = DC, so IC wins the first tie. Reset mid-burst aborts the burst immediately with no Done pulse; the requester re-requests after reset.
- **IDLE:**
  - IC_REQ only -> GNT_IC.
  - DC_REQ only -> GNT_DC.
  - Both -> grant the requester not equal to the pointer.
  - On grant: latch the base address = ADDR with the low log2(Burst_len)+2 bits cleared, latch DC_WE (0 for IC), clear the beat counter.
- **GNT_x:**
  - MEM_REQ=1 combinationally.
  - MEM_ADDR = base + (beat << 2).
  - MEM_WE = latched WE.
  - MEM_WDATA = DC_WDATA when GNT_DC and WE, else 0.
  - x_WORD = beat.
- **On MEM_Ack in GNT_x:**
  - x_Valid=1. x_Data = MEM_RDATA for reads, 0 for writes. The non-granted side's Data/Valid stay 0.
  - Beat increments, wrapping to 0 after Burst_len-1.
  - If beat == Burst_len-1: x_Done=1 in the same cycle, pointer <- x, next state IDLE.
- **Latency:**
  - One cycle from REQ sampled in IDLE to MEM_REQ.
  - With zero-wait memory (Ack tied high), a burst is exactly Burst_len cycles.
  - A mandatory one-cycle IDLE turnaround occurs between bursts.
- **Memory wait states:** MEM_Ack may stay low any number of cycles. MEM_ADDR, MEM_WE and MEM_WDATA stay stable until Ack.
- **Requester rules:**
  - REQ must stay high until Done.
  - REQ dropping mid-burst is ignored; the burst completes.
  - DC_WDATA must track DC_WORD combinationally or within the same cycle.
- **Fairness:** a requester still asserting REQ after Done is not re-granted if the other is waiting.
- **MEM_Ack outside GNT states:** ignored.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, GNT_IC=2'b01, GNT_DC=2'b10;
  - BEAT_BITS = clog2(Burst_len);
  - OFFSET_BITS = BEAT_BITS+2;
  - requester IDs (REQ_IC=0, REQ_DC=1).
- One sub-module: mem_burst_beat_counter (clear, enable on Ack, beat value, last flag).
- Arbitration and muxing stay in the top.

Test Plan:
1. IC_REQ=1, IC_ADDR=0x0000_1234, Ack tied high -> MEM_ADDR 0x1220,0x1224..0x123C on 8 consecutive cycles; IC_WORD 0..7; IC_Done on beat 7; DC outputs stay 0.
2. IC_REQ and DC_REQ both rise in the same cycle after reset -> IC granted first; after IC_Done, one IDLE cycle, then GNT_DC; next tie -> IC.
3. DC_REQ=1, DC_WE=1, DC_ADDR=0x400, Ack high only every 3rd cycle -> MEM_WE=1; MEM_ADDR holds each beat until Ack; 8 DC_Valid pulses; DC_Done on the 8th Ack.
4. Assert RST at beat 4 of an IC burst -> next cycle all outputs 0, state IDLE, no IC_Done; after release, IC_REQ restarts at beat 0.
5. IC_REQ drops at beat 2 -> burst continues to beat 7 with IC_Done; DC_REQ held high throughout is granted after the turnaround cycle.
